// File: rtl/resilient_stage_if.sv
// Four-phase left/right channel bundle for one timing-resilient pipeline stage.
// The master drives requests/data towards the stage; the slave is the stage itself.
interface resilient_stage_if #(
  parameter int WIDTH = 8
);
  logic             l_req;
  logic             l_ack;
  logic [WIDTH-1:0] l_data;
  logic             r_req;
  logic             r_ack;
  logic [WIDTH-1:0] r_data;

  modport master (
    output l_req, l_data, r_ack,
    input  l_ack, r_req, r_data
  );

  modport slave (
    input  l_req, l_data, r_ack,
    output l_ack, r_req, r_data
  );
endinterface

// File: rtl/resilient_stage_ctrl.sv
// Timing-resilient stage controller: captures a left token, watches a shadow-latch
// error window, substitutes the corrected value and forwards it on the right channel.
module resilient_stage_ctrl #(
  parameter int             WIDTH      = 8,
  parameter int             ERR_WINDOW = 4,
  parameter int             RECOVER    = 2,
  parameter bit             TOKEN      = 1'b0,
  parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b0}},
  parameter int             CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  resilient_stage_if.slave  ch,
  input  logic              err,
  input  logic [WIDTH-1:0]  shadow_data,
  output logic              latch_en,
  output logic              sample,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WIN  = 3'd1;
  localparam logic [2:0] S_RCV  = 3'd2;
  localparam logic [2:0] S_HS   = 3'd3;
  localparam logic [2:0] S_RTZ  = 3'd4;

  // The shared down-counter only ever holds values up to max(ERR_WINDOW, RECOVER)-1.
  localparam int CNT_MAX = (ERR_WINDOW > RECOVER) ? ERR_WINDOW : RECOVER;
  localparam int TW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ERR_SAT = {CNT_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             err_flag_q, err_flag_d;
  logic             left_done_q, left_done_d;
  logic [WIDTH-1:0] r_data_q, r_data_d;
  logic             l_ack_q, l_ack_d;
  logic             r_req_q, r_req_d;
  logic             latch_en_q, latch_en_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             flag_now_s;
  logic             win_err_s;

  // Next-state logic for the stage FSM, data register and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_flag_d  = err_flag_q;
    left_done_d = left_done_q;
    r_data_d    = r_data_q;
    l_ack_d     = l_ack_q;
    r_req_d     = r_req_q;
    latch_en_d  = 1'b0;
    win_err_s   = 1'b0;
    flag_now_s  = err_flag_q | err;

    case (state_q)
      S_IDLE: begin
        if (ch.l_req) begin
          r_data_d   = ch.l_data;
          cnt_d      = TW'(ERR_WINDOW - 1);
          err_flag_d = 1'b0;
          latch_en_d = 1'b1;
          state_d    = S_WIN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WIN: begin
        if (err) begin
          r_data_d = shadow_data;
        end else begin
          r_data_d = r_data_q;
        end
        err_flag_d = flag_now_s;
        if (cnt_q == TW'(0)) begin
          win_err_s = flag_now_s;
          if (flag_now_s && (RECOVER > 0)) begin
            cnt_d   = TW'(RECOVER - 1);
            state_d = S_RCV;
          end else begin
            r_req_d = 1'b1;
            l_ack_d = ~left_done_q;
            state_d = S_HS;
          end
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_RCV: begin
        if (cnt_q == TW'(0)) begin
          r_req_d = 1'b1;
          l_ack_d = ~left_done_q;
          state_d = S_HS;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_HS: begin
        if (r_req_q && ch.r_ack) begin
          r_req_d = 1'b0;
        end else begin
          r_req_d = r_req_q;
        end
        if (l_ack_q && !ch.l_req) begin
          l_ack_d = 1'b0;
        end else begin
          l_ack_d = l_ack_q;
        end
        // Both sides returned: RTZ also covers an r_ack that already dropped here.
        if (!r_req_q && !l_ack_q) begin
          state_d = S_RTZ;
        end else begin
          state_d = S_HS;
        end
      end
      S_RTZ: begin
        if (!ch.r_ack) begin
          left_done_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RTZ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Saturating error counter; a clear wins over holding, and clear+increment gives 1.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = win_err_s ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (win_err_s && (err_count_q != ERR_SAT)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State registers with synchronous reset into the idle or token-holding state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TOKEN ? S_HS : S_IDLE;
      cnt_q       <= {TW{1'b0}};
      err_flag_q  <= 1'b0;
      left_done_q <= TOKEN;
      r_data_q    <= INIT;
      l_ack_q     <= 1'b0;
      r_req_q     <= TOKEN;
      latch_en_q  <= 1'b0;
      err_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_flag_q  <= err_flag_d;
      left_done_q <= left_done_d;
      r_data_q    <= r_data_d;
      l_ack_q     <= l_ack_d;
      r_req_q     <= r_req_d;
      latch_en_q  <= latch_en_d;
      err_count_q <= err_count_d;
    end
  end

  assign ch.l_ack  = l_ack_q;
  assign ch.r_req  = r_req_q;
  assign ch.r_data = r_data_q;
  assign latch_en  = latch_en_q;
  assign err_count = err_count_q;
  assign sample    = (state_q == S_WIN);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// Scoreboard bench for resilient_stage_ctrl: one TOKEN=0 stage with a 2-bit counter
// and one TOKEN=1 stage checked for its reset token.
module tb_resilient_stage_ctrl;
  localparam int W       = 8;
  localparam int EW      = 4;
  localparam int RC      = 2;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  resilient_stage_if #(.WIDTH(W)) ifa ();
  resilient_stage_if #(.WIDTH(W)) ifb ();

  logic          err_a, err_clr_a, latch_en_a, sample_a, busy_a;
  logic [W-1:0]  shadow_a;
  logic [CW-1:0] cnt_a;
  logic          err_b, err_clr_b, latch_en_b, sample_b, busy_b;
  logic [W-1:0]  shadow_b;
  logic [7:0]    cnt_b;

  resilient_stage_ctrl #(.WIDTH(W), .ERR_WINDOW(EW), .RECOVER(RC), .TOKEN(1'b0),
                         .INIT(8'h00), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .ch(ifa), .err(err_a), .shadow_data(shadow_a),
    .latch_en(latch_en_a), .sample(sample_a), .err_clr(err_clr_a),
    .err_count(cnt_a), .busy(busy_a)
  );

  resilient_stage_ctrl #(.WIDTH(W), .ERR_WINDOW(EW), .RECOVER(RC), .TOKEN(1'b1),
                         .INIT(8'h33), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .ch(ifb), .err(err_b), .shadow_data(shadow_b),
    .latch_en(latch_en_b), .sample(sample_b), .err_clr(err_clr_b),
    .err_count(cnt_b), .busy(busy_b)
  );

  typedef struct {
    logic [W-1:0]  data;
    int            lat;
    int            cap;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   model_cnt = 0;
  logic rreq_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return ifa.l_ack;
      1:       return ifa.r_req;
      2:       return busy_a;
      3:       return ifb.r_req;
      4:       return busy_b;
      5:       return ifb.l_ack;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int sel, input logic val);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sig_of(sel) == val) break;
    end
    chk(tag, sig_of(sel), val);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard pop on every rising r_req of stage A.
  always @(negedge clk) begin
    if (!rst && ifa.r_req && !rreq_prev) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk("r_data", ifa.r_data, sb[0].data);
        chk("latency", cyc - sb[0].cap, sb[0].lat);
        chk("err_count", cnt_a, sb[0].cnt);
        void'(sb.pop_front());
      end
    end
    rreq_prev <= ifa.r_req;
  end

  task automatic send_token(input logic [7:0] d, input logic [3:0] eb, input logic [7:0] sh,
                            input logic clr, input int stall);
    exp_t e;
    logic has_err;
    has_err = (eb != 4'b0000);
    if (clr) model_cnt = has_err ? 1 : 0;
    else if (has_err && model_cnt < CNT_MAX) model_cnt++;
    e.data = has_err ? sh : d;
    e.lat  = EW + (has_err ? RC : 0);
    e.cap  = cyc + 1;
    e.cnt  = model_cnt[CW-1:0];
    chk("idle_before", busy_a, 1'b0);
    ifa.l_req  = 1'b1;
    ifa.l_data = d;
    shadow_a   = sh;
    sb.push_back(e);
    for (int i = 0; i < EW; i++) begin
      @(negedge clk);
      chk("sample", sample_a, 1'b1);
      chk("latch_en", latch_en_a, (i == 0));
      err_a     = eb[i];
      err_clr_a = clr && (i == EW - 1);
    end
    @(negedge clk);
    err_a     = 1'b0;
    err_clr_a = 1'b0;
    shadow_a  = ~sh;
    chk("sample_closed", sample_a, 1'b0);
    wait_until("l_ack_rise", 0, 1'b1);
    ifa.l_req  = 1'b0;
    ifa.l_data = ~d;
    wait_until("l_ack_fall", 0, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_r_req", ifa.r_req, 1'b1);
      chk("stall_r_data", ifa.r_data, e.data);
      chk("stall_latch", latch_en_a, 1'b0);
    end
    ifa.r_ack = 1'b1;
    wait_until("r_req_fall", 1, 1'b0);
    ifa.r_ack = 1'b0;
    wait_until("back_idle", 2, 1'b0);
  endtask

  logic [7:0] td [10] = '{8'h5A, 8'h3C, 8'hC3, 8'h96, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
  logic [3:0] te [10] = '{4'b0000, 4'b1000, 4'b1111, 4'b0000, 4'b0001,
                          4'b0010, 4'b0100, 4'b1001, 4'b0110, 4'b0001};
  logic [7:0] ts [10] = '{8'hEE, 8'hA5, 8'h0F, 8'hEE, 8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifa.l_req = 1'b0; ifa.l_data = 8'h00; ifa.r_ack = 1'b0;
    ifb.l_req = 1'b0; ifb.l_data = 8'h00; ifb.r_ack = 1'b0;
    err_a = 1'b0; err_clr_a = 1'b0; shadow_a = 8'h00;
    err_b = 1'b0; err_clr_b = 1'b0; shadow_b = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_l_ack", ifa.l_ack, 1'b0);
    chk("rst_a_r_req", ifa.r_req, 1'b0);
    chk("rst_a_latch", latch_en_a, 1'b0);
    chk("rst_a_sample", sample_a, 1'b0);
    chk("rst_a_r_data", ifa.r_data, 8'h00);
    chk("rst_a_cnt", cnt_a, 2'd0);
    chk("rst_a_busy", busy_a, 1'b0);
    chk("rst_b_r_req", ifb.r_req, 1'b1);
    chk("rst_b_r_data", ifb.r_data, 8'h33);
    chk("rst_b_l_ack", ifb.l_ack, 1'b0);

    for (int t = 0; t < 4; t++) send_token(td[t], te[t], ts[t], 1'b0, (t == 3) ? 10 : 0);

    @(negedge clk);
    err_clr_a = 1'b1;
    model_cnt = 0;
    @(negedge clk);
    err_clr_a = 1'b0;
    chk("clr_alone", cnt_a, 2'd0);

    for (int t = 4; t < 9; t++) send_token(td[t], te[t], ts[t], 1'b0, 0);
    chk("saturated", cnt_a, CNT_MAX);
    send_token(td[9], te[9], ts[9], 1'b1, 0);
    chk("clr_with_inc", cnt_a, 2'd1);

    ifb.r_ack = 1'b1;
    wait_until("b_r_req_fall", 3, 1'b0);
    ifb.r_ack = 1'b0;
    wait_until("b_idle", 4, 1'b0);
    ifb.l_req  = 1'b1;
    ifb.l_data = 8'h77;
    repeat (EW + 1) @(negedge clk);
    chk("b_tok_r_req", ifb.r_req, 1'b1);
    chk("b_tok_l_ack", ifb.l_ack, 1'b1);
    chk("b_tok_r_data", ifb.r_data, 8'h77);
    ifb.l_req = 1'b0;
    wait_until("b_l_ack_fall", 5, 1'b0);

    ifa.l_req  = 1'b1;
    ifa.l_data = 8'h11;
    @(negedge clk);
    chk("win_before_rst", sample_a, 1'b1);
    rst = 1'b1;
    ifa.l_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_sample", sample_a, 1'b0);
    chk("mid_rst_latch", latch_en_a, 1'b0);
    chk("mid_rst_r_req", ifa.r_req, 1'b0);
    chk("mid_rst_l_ack", ifa.l_ack, 1'b0);
    chk("mid_rst_r_data", ifa.r_data, 8'h00);
    chk("mid_rst_cnt", cnt_a, 2'd0);
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_b_r_req", ifb.r_req, 1'b1);
    chk("mid_rst_b_r_data", ifb.r_data, 8'h33);
    rst = 1'b0;
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
